cacheline_burst_adapter: RTL and testbench
==========================================

// Module: cacheline_burst_adapter
// PURPOSE
//  Sits between the dcache datapath/control (256-bit line port) and physical memory (64-bit burst port).
//  Serialises a dirty-line writeback into 4 beats and assembles 4 read beats into one fill line.
//  One transaction at a time; the cache side sees one resp pulse per completed line.
// PARAMETERS
//  LINE_W   256  cache line width, bits
//  BURST_W  64   memory beat width, bits
//  BEATS    LINE_W/BURST_W (4), derived; not overridable
//  ADDR_W   32   address width
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous, active-low reset
//  line_i      in   LINE_W   line to write back (cache pmem_wdata)
//  line_o      out  LINE_W   assembled fill line (cache pmem_rdata)
//  address_i   in   ADDR_W   line address from cache (pmem_address)
//  read_i      in   1        cache requests line fill; held until resp_o
//  write_i     in   1        cache requests writeback; held until resp_o
//  resp_o      out  1        1-cycle pulse: transaction complete
//  burst_i     in   BURST_W  read beat from memory
//  burst_o     out  BURST_W  write beat to memory
//  address_o   out  ADDR_W   line-aligned burst address to memory
//  read_o      out  1        burst read request
//  write_o     out  1        burst write request
//  resp_i      in   1        memory beat strobe (one per beat)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, beat count 0, line_o=0, read_o=write_o=resp_o=0,
//   burst_o=0, address_o=0. Applies immediately, including mid-burst; partial burst abandoned.
//  FSM: IDLE, RD_BURST, WR_BURST, DONE. read_o/write_o/resp_o are decoded from state only.
//  IDLE: if write_i -> latch line_i, address_i -> WR_BURST; else if read_i -> latch address_i -> RD_BURST.
//   write_i wins when both are high (writeback precedes fill). resp_i in IDLE or DONE ignored.
//  Latched address: {address_i[ADDR_W-1:5], 5'b0}; address_o holds it for the whole burst.
//  RD_BURST: read_o=1. On each resp_i, burst_i -> line_o[64*cnt +: 64], cnt++.
//   On the 4th beat (cnt==3 && resp_i) -> DONE, cnt=0.
//  WR_BURST: write_o=1, burst_o = latched_line[64*cnt +: 64]. On resp_i cnt++; 4th beat -> DONE.
//  Beat order: beat 0 = bits [63:0], ascending. Gaps between beats (resp_i low) stall cnt; no timeout.
//  DONE: resp_o=1 for exactly one cycle -> IDLE. line_o stable from DONE until the next read's first beat.
//  Requester must deassert read_i/write_i in the cycle after resp_o; a still-high request starts a new
//   transaction. Deassertion of read_i/write_i mid-burst is ignored; the burst completes.
//  Changes on line_i/address_i after acceptance do not affect the burst in progress.
//  Latency: request sampled in IDLE at cycle N; read_o/write_o high from N+1. With resp_i high from N+1
//   every cycle, resp_o at N+5; next request accepted no earlier than N+6.
// STRUCTURE
//  Shared package cache_pkg: LINE_W, BURST_W, BEATS, ADDR_W constants and the adapter state enum
//   (also imported by the dcache control FSM for width checks).
//  Single module. Line register, 2-bit beat counter and FSM are local; no sub-module.
// TESTING
//  Read, resp_i 4 consecutive cycles, beats 64'h0..0, 1, 2, 3 -> line_o = {3,2,1,0}; resp_o at N+5; read_o low after.
//  Write line_i = 256'hDDDD..CCCC..BBBB..AAAA (4x64) -> burst_o A,B,C,D on successive resp_i; one resp_o pulse.
//  address_i = 32'h1234_567F -> address_o = 32'h1234_5660 for all 4 beats.
//  Read with resp_i gaps (1,0,0,1,1,0,1) -> same line as gap-free case; resp_o only after 4th strobe.
//  read_i and write_i both high in IDLE -> write burst first, write_o=1, read_o=0 until resp_o.
//  rst_n low after 2 read beats -> read_o=0, line_o=0 immediately; next read assembles a clean line.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ===========================================================================
// cache_pkg: shared line/burst geometry and burst adapter state encoding
// Revision 1.0
// ===========================================================================
package cache_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int ADDR_W  = 32;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int CNT_W   = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adapter_state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << OFF_W) - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_burst_adapter.sv
`default_nettype none
// ===========================================================================
// cacheline_burst_adapter: 256-bit cache line <-> 4 x 64-bit memory bursts
// Revision 1.0
// ===========================================================================
module cacheline_burst_adapter
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adapter_state_e    state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0] line_buf;
  logic [ADDR_W-1:0] addr_buf;

  assign address_o = addr_buf;
  assign burst_o   = write_o ? line_buf[int'(beat_cnt)*BURST_W +: BURST_W] : '0;

  // read_o/write_o/resp_o are registered alongside the state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      line_buf <= '0;
      addr_buf <= '0;
      line_o   <= '0;
      read_o   <= 1'b0;
      write_o  <= 1'b0;
      resp_o   <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (write_i) begin
            line_buf <= line_i;
            addr_buf <= line_align(address_i);
            write_o  <= 1'b1;
            state    <= WR_BURST;
          end else if (read_i) begin
            addr_buf <= line_align(address_i);
            read_o   <= 1'b1;
            state    <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[int'(beat_cnt)*BURST_W +: BURST_W] <= burst_i;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              read_o   <= 1'b0;
              resp_o   <= 1'b1;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              write_o  <= 1'b0;
              resp_o   <= 1'b1;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
`default_nettype none
// ===========================================================================
// tb_cacheline_burst_adapter: directed vector bench for the line/burst adapter
// Revision 1.0
// ===========================================================================
module tb_cacheline_burst_adapter;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  int n_checks = 0;
  int n_errors = 0;

  cacheline_burst_adapter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;      // line_i for writes, beat source for reads
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp;       // expected line_o (read) or burst_o sequence (write)
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    read_i    = !v.wr;
    write_i   = v.wr;
    address_i = v.addr;
    line_i    = v.wr ? v.data : '0;
    resp_i    = 1'b0;
    @(negedge clk);
    line_i    = ~v.data;
    address_i = ~v.addr;
    for (int k = 0; k < BEATS; k++) begin
      chk("read_o_busy", read_o, !v.wr);
      chk("write_o_busy", write_o, v.wr);
      chk("address_o", address_o, v.exp_addr);
      chk("resp_o_early", resp_o, 1'b0);
      if (v.wr) chk("burst_o", burst_o, v.exp[k*BURST_W +: BURST_W]);
      resp_i  = 1'b1;
      burst_i = v.wr ? 64'hBAD0_BAD0_BAD0_BAD0 : v.data[k*BURST_W +: BURST_W];
      @(negedge clk);
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    chk("resp_o", resp_o, 1'b1);
    chk("read_o_done", read_o, 1'b0);
    chk("write_o_done", write_o, 1'b0);
    if (!v.wr) chk("line_o", line_o, v.exp);
    @(negedge clk);
    chk("resp_o_pulse", resp_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] rd0;
    logic [6:0]        gaps;
    int                b;
    vec_t              v;

    vecs[0] = '{1'b0, 32'h0000_1000,
                {64'h3, 64'h2, 64'h1, 64'h0}, 32'h0000_1000,
                {64'h3, 64'h2, 64'h1, 64'h0}};
    vecs[1] = '{1'b1, 32'h1234_567F,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 32'h1234_5660,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'h8000_0000_0000_0001}, 32'hFFFF_FFE0,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'h8000_0000_0000_0001}};
    vecs[3] = '{1'b1, 32'h0000_001F,
                {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}, 32'h0000_0000,
                {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}};
    rd0 = {64'h3, 64'h2, 64'h1, 64'h0};

    rst_n = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Fill line from the first read, then memory strobes while idle must be ignored.
    run_txn(vecs[0]);
    resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); @(negedge clk);
    resp_i = 1'b0;
    chk("idle_read_o", read_o, 1'b0);
    chk("idle_write_o", write_o, 1'b0);
    chk("idle_line_o", line_o, rd0);

    // Read with strobe gaps 1,0,0,1,1,0,1.
    gaps = 7'b1011001;
    read_i = 1'b1; address_i = 32'h0000_2040;
    @(negedge clk);
    b = 0;
    for (int j = 0; j < 7; j++) begin
      chk("gap_read_o", read_o, 1'b1);
      chk("gap_resp_o", resp_o, 1'b0);
      resp_i  = gaps[j];
      burst_i = gaps[j] ? 64'(b) : 64'hDEAD_DEAD_DEAD_DEAD;
      if (gaps[j]) b++;
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0;
    chk("gap_resp_o_end", resp_o, 1'b1);
    chk("gap_line_o", line_o, rd0);
    chk("gap_address_o", address_o, 32'h0000_2040);
    @(negedge clk);

    // Both requests high: writeback first, then the held read starts a fill.
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_3003;
    line_i = {64'h4, 64'h3, 64'h2, 64'h1};
    @(negedge clk);
    for (int k = 0; k < BEATS; k++) begin
      chk("both_write_o", write_o, 1'b1);
      chk("both_read_o", read_o, 1'b0);
      chk("both_burst_o", burst_o, 64'(k + 1));
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0; write_i = 1'b0;
    chk("both_resp_o", resp_o, 1'b1);
    @(negedge clk);
    chk("both_gap_read_o", read_o, 1'b0);
    @(negedge clk);
    chk("both_fill_read_o", read_o, 1'b1);
    chk("both_fill_address_o", address_o, 32'h0000_3000);
    read_i = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      resp_i = 1'b1; burst_i = 64'(16 + k);
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("both_fill_line_o", line_o, {64'd19, 64'd18, 64'd17, 64'd16});
    @(negedge clk);

    // Reset after two read beats abandons the burst.
    read_i = 1'b1; address_i = 32'h0000_4000;
    @(negedge clk);
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = 64'h7777_7777_7777_7777;
      @(negedge clk);
    end
    resp_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", address_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    v = vecs[2];
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
